// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_core slice.
// TX/RX state encodings and the bit-period calculation used to size the
// baud counters.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clock cycles per serial bit; integer division, remainder discarded.
  function automatic int clks_per_bit(input int sys_clk_hz, input int baud);
    return sys_clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_core_if.sv
// uart_core_if: parallel byte-stream client handshake for uart_core.
// master = client side, slave = the UART core.
interface uart_core_if #(
  parameter int DataLength = 8
);

  logic [DataLength-1:0] i_tx_data;
  logic                  i_tx_req;
  logic                  o_tx_rdy;
  logic [DataLength-1:0] o_rx_data;
  logic                  i_rx_req;
  logic                  o_rx_rdy;
  logic                  o_rx_error;

  modport master (
    output i_tx_data, i_tx_req, i_rx_req,
    input  o_tx_rdy, o_rx_data, o_rx_rdy, o_rx_error
  );

  modport slave (
    input  i_tx_data, i_tx_req, i_rx_req,
    output o_tx_rdy, o_rx_data, o_rx_rdy, o_rx_error
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word fall-through read.
// o_rd_data shows the head entry while not empty; once drained it keeps
// showing the last entry that was popped (zero after reset).
// Writes while full and reads while empty are ignored.
module uart_sync_fifo #(
  parameter int DataLength = 8,
  parameter int FifoDepth  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DataLength-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DataLength-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(FifoDepth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DataLength-1:0] mem [FifoDepth];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DataLength-1:0] last_q;
  logic                  wr_fire;
  logic                  rd_fire;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_fire = i_wr_en & ~o_full;
  assign rd_fire = i_rd_en & ~o_empty;

  // Read/write pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Last popped entry, shown on the read port while the FIFO is empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= '0;
    end else if (rd_fire) begin
      last_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  assign o_rd_data = o_empty ? last_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with TX/RX FIFOs and optional RTS/CTS.
// Optional build macro UART_LOOPBACK_EN adds i_loopback, which routes o_tx
// into the RX synchronizer in place of i_rx.
module uart_core
  import uart_pkg::*;
#(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 133_000_000,
  parameter int FlowControl     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  uart_core_if.slave  bus,
  input  logic        i_rx,
  output logic        o_tx,
  input  logic        i_cts,
  output logic        o_rts
`ifdef UART_LOOPBACK_EN
  ,
  input  logic        i_loopback
`endif
);

  localparam int CPB  = clks_per_bit(SystemClockFreq, BaudRate);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = (DataLength > 1) ? $clog2(DataLength) : 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DataLength - 1);

  // ---------------- input synchronizers ----------------
  logic       rx_src;
  logic [1:0] rx_sync;
  logic [1:0] cts_sync;
  logic       rx_s;
  logic       cts_s;
  logic       tx_q;

`ifdef UART_LOOPBACK_EN
  assign rx_src = i_loopback ? tx_q : i_rx;
`else
  assign rx_src = i_rx;
`endif

  // Two-flop synchronizers; RX resets to idle-high, CTS to "not permitted".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync  <= 2'b11;
      cts_sync <= 2'b00;
    end else begin
      rx_sync  <= {rx_sync[0], rx_src};
      cts_sync <= {cts_sync[0], i_cts};
    end
  end

  assign rx_s  = rx_sync[1];
  assign cts_s = cts_sync[1];

  // ---------------- FIFOs ----------------
  logic [DataLength-1:0] tx_head;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_pop;
  logic [DataLength-1:0] rx_shift;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_push;

  uart_sync_fifo #(
    .DataLength (DataLength),
    .FifoDepth  (FifoDepth)
  ) u_tx_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (bus.i_tx_req),
    .i_wr_data (bus.i_tx_data),
    .i_rd_en   (tx_pop),
    .o_rd_data (tx_head),
    .o_full    (tx_full),
    .o_empty   (tx_empty)
  );

  uart_sync_fifo #(
    .DataLength (DataLength),
    .FifoDepth  (FifoDepth)
  ) u_rx_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (rx_push),
    .i_wr_data (rx_shift),
    .i_rd_en   (bus.i_rx_req),
    .o_rd_data (bus.o_rx_data),
    .o_full    (rx_full),
    .o_empty   (rx_empty)
  );

  assign bus.o_tx_rdy = ~tx_full;
  assign bus.o_rx_rdy = ~rx_empty;
  assign o_rts        = (FlowControl != 0) ? ~rx_full : 1'b1;

  // ---------------- transmitter ----------------
  tx_state_t             tx_state;
  tx_state_t             tx_state_nx;
  logic [CW-1:0]         tx_cnt;
  logic [CW-1:0]         tx_cnt_nx;
  logic [BW-1:0]         tx_bit;
  logic [BW-1:0]         tx_bit_nx;
  logic [DataLength-1:0] tx_shift;
  logic [DataLength-1:0] tx_shift_nx;
  logic                  tx_nx;
  logic                  tx_go;

  // Flow control is sampled only here, so a CTS drop mid-frame lets it finish.
  assign tx_go = ~tx_empty & ((FlowControl == 0) | cts_s);

  // TX next-state: pop into the shift register, then start/data/stop bits.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + CNT_ONE;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    tx_nx       = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (tx_go) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_head;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = tx_shift >> 1;
          if (tx_bit == BIT_LAST) tx_state_nx = TX_STOP;
          else                    tx_bit_nx   = tx_bit + BIT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    // Line level is registered from the next state so o_tx is glitch-free.
    case (tx_state_nx)
      TX_START: tx_nx = 1'b0;
      TX_DATA:  tx_nx = tx_shift_nx[0];
      default:  tx_nx = 1'b1;
    endcase
  end

  // TX control registers; reset forces the line back to idle at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_q     <= tx_nx;
    end
  end

  // TX shift register (data path, no reset).
  always_ff @(posedge i_clk) begin
    tx_shift <= tx_shift_nx;
  end

  assign o_tx = tx_q;

  // ---------------- receiver ----------------
  rx_state_t             rx_state;
  rx_state_t             rx_state_nx;
  logic [CW-1:0]         rx_cnt;
  logic [CW-1:0]         rx_cnt_nx;
  logic [BW-1:0]         rx_bit;
  logic [BW-1:0]         rx_bit_nx;
  logic [DataLength-1:0] rx_shift_nx;
  logic                  rx_err;
  logic                  rx_err_set;

  // RX next-state: qualify start at half bit, sample at bit centres.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + CNT_ONE;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    rx_err_set  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (!rx_s) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_nx = '0;
          if (!rx_s) begin
            rx_bit_nx   = '0;
            rx_state_nx = RX_DATA;
          end else begin
            rx_state_nx = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s, rx_shift[DataLength-1:1]};
          if (rx_bit == BIT_LAST) rx_state_nx = RX_STOP;
          else                    rx_bit_nx   = rx_bit + BIT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = RX_IDLE;
          // Bad stop bit (framing) or no room (overrun) both drop the byte.
          if (rx_s && !rx_full) rx_push    = 1'b1;
          else                  rx_err_set = 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // RX control registers and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_err   <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      if (rx_err_set) rx_err <= 1'b1;
    end
  end

  // RX shift register (data path, no reset).
  always_ff @(posedge i_clk) begin
    rx_shift <= rx_shift_nx;
  end

  assign bus.o_rx_error = rx_err;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed self-checking bench for uart_core.
// Runs the core at 17 clocks per bit (1.7 MHz / 100 kbaud) to keep frames short.
module tb_uart_core;

  localparam int CPB  = 17;
  localparam int HALF = 8;
  localparam int LIM  = 3000;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_rx;
  logic o_tx;
  logic i_cts;
  logic o_rts;

  int n_total = 0;
  int n_bad   = 0;

  uart_core_if #(.DataLength(8)) bus ();

  uart_core #(
    .DataLength      (8),
    .FifoDepth       (8),
    .BaudRate        (100_000),
    .SystemClockFreq (1_700_000),
    .FlowControl     (1)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus),
    .i_rx  (i_rx),
    .o_tx  (o_tx),
    .i_cts (i_cts),
    .o_rts (o_rts)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] tx_vec  [8] = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3};
  logic [7:0] rx_vec  [8] = '{8'h5A, 8'h01, 8'hFE, 8'h80, 8'h33, 8'hCC, 8'h7F, 8'h96};
  logic [7:0] cts_vec [8] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h0F, 8'hF0, 8'h69, 8'h96};
  logic [7:0] ovr_vec [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx"},     o_tx,           1);
    chk({tag, "_txrdy"},  bus.o_tx_rdy,   1);
    chk({tag, "_rxrdy"},  bus.o_rx_rdy,   0);
    chk({tag, "_err"},    bus.o_rx_error, 0);
    chk({tag, "_rxdata"}, bus.o_rx_data,  0);
    chk({tag, "_rts"},    o_rts,          1);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset(tag);
    i_rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge i_clk);
    bus.i_tx_data = d;
    bus.i_tx_req  = 1'b1;
    @(posedge i_clk);
    #1 bus.i_tx_req = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge i_clk);
    chk(tag, bus.o_rx_data, exp);
    bus.i_rx_req = 1'b1;
    @(negedge i_clk);
    bus.i_rx_req = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge i_clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    i_rx = 1'b1;
  endtask

  // Called at a negedge; decodes one frame from o_tx, sampling each bit at
  // its first, middle and last cycle so any bit-period error shows up.
  task automatic mon_frame(input logic [7:0] exp);
    int         t;
    logic [7:0] got;
    logic       tim_ok;
    logic       v0, v8, v16, start_v, stop_v;
    t = 0;
    while (o_tx !== 1'b0 && t < LIM) begin
      @(negedge i_clk);
      t++;
    end
    chk("tx_start_seen", (t < LIM), 1);
    if (t >= LIM) return;
    tim_ok = 1'b1;
    got = '0; start_v = 1'b1; stop_v = 1'b0;
    v0 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0)       v0  = o_tx;
        if (c == HALF)    v8  = o_tx;
        if (c == CPB - 1) v16 = o_tx;
        @(negedge i_clk);
      end
      if (v0 !== v8 || v16 !== v8) tim_ok = 1'b0;
      if (b == 0)      start_v  = v8;
      else if (b == 9) stop_v   = v8;
      else             got[b-1] = v8;
    end
    chk("tx_byte", got, exp);
    chk("tx_bit_timing", tim_ok, 1);
    chk("tx_start_stop", {start_v, stop_v}, 2'b01);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic ok;
    ok = 1'b1;
    repeat (cycles) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) ok = 1'b0;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    i_rst = 1'b1; i_rx = 1'b1; i_cts = 1'b1;
    bus.i_tx_data = '0; bus.i_tx_req = 1'b0; bus.i_rx_req = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset("rst0");
    i_rst = 1'b0;

    // TX: 8 bytes back to back
    fork
      begin
        for (int i = 0; i < 8; i++) push(tx_vec[i]);
      end
      begin
        @(negedge i_clk);
        for (int i = 0; i < 8; i++) mon_frame(tx_vec[i]);
      end
    join
    quiet("tx_idle_after", 2 * CPB);

    // RX: 8 frames, then drain in order
    for (int i = 0; i < 8; i++) send_frame(rx_vec[i], 1'b1);
    repeat (3) @(negedge i_clk);
    chk("rx_rdy_full", bus.o_rx_rdy, 1);
    chk("rx_rts_full", o_rts, 0);
    for (int i = 0; i < 8; i++) pop_chk("rx_pop", rx_vec[i]);
    @(negedge i_clk);
    chk("rx_rdy_empty", bus.o_rx_rdy, 0);
    chk("rx_hold_last", bus.o_rx_data, 8'h96);
    chk("rx_err_clean", bus.o_rx_error, 0);

    // Framing error, reset, then a good frame
    send_frame(8'h3C, 1'b0);
    repeat (10) @(negedge i_clk);
    chk("frm_err", bus.o_rx_error, 1);
    chk("frm_no_byte", bus.o_rx_rdy, 0);
    reset_pulse("rst1");
    send_frame(8'hA5, 1'b1);
    repeat (3) @(negedge i_clk);
    chk("frm_after_rdy", bus.o_rx_rdy, 1);
    pop_chk("frm_after_data", 8'hA5);
    @(negedge i_clk);
    chk("frm_after_empty", bus.o_rx_rdy, 0);

    // Short low glitch (under half a bit) must be rejected silently
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (10 * CPB) @(negedge i_clk);
    chk("glitch_rdy", bus.o_rx_rdy, 0);
    chk("glitch_err", bus.o_rx_error, 0);
    send_frame(8'hC3, 1'b1);
    repeat (3) @(negedge i_clk);
    pop_chk("glitch_after", 8'hC3);

    // CTS low: fill TX FIFO, line must stay idle, extra push ignored
    i_cts = 1'b0;
    repeat (4) @(negedge i_clk);
    for (int i = 0; i < 8; i++) push(cts_vec[i]);
    chk("cts_tx_rdy_full", bus.o_tx_rdy, 0);
    push(8'hEE);
    quiet("cts_hold_tx", 60);
    // Raise CTS, drop it mid-frame: only the current frame completes
    @(negedge i_clk);
    i_cts = 1'b1;
    fork
      mon_frame(cts_vec[0]);
      begin
        repeat (40) @(negedge i_clk);
        i_cts = 1'b0;
      end
    join
    quiet("cts_midframe_stop", 4 * CPB);
    chk("cts_tx_rdy_room", bus.o_tx_rdy, 1);
    i_cts = 1'b1;
    @(negedge i_clk);
    for (int i = 1; i < 8; i++) mon_frame(cts_vec[i]);
    quiet("cts_no_extra", 3 * CPB);

    // Reset in the middle of a frame returns the line high immediately
    push(8'h00);
    t = 0;
    while (o_tx !== 1'b0 && t < LIM) begin
      @(negedge i_clk);
      t++;
    end
    chk("mid_start_seen", (t < LIM), 1);
    repeat (30) @(negedge i_clk);
    chk("mid_line_low", o_tx, 0);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_tx", o_tx, 1);
    @(negedge i_clk);
    i_rst = 1'b0;
    quiet("mid_no_resume", 3 * CPB);

    // Overrun: 9 frames without popping
    for (int i = 0; i < 8; i++) send_frame(ovr_vec[i], 1'b1);
    repeat (3) @(negedge i_clk);
    chk("ovr_rts_low", o_rts, 0);
    chk("ovr_err_before", bus.o_rx_error, 0);
    send_frame(ovr_vec[8], 1'b1);
    repeat (3) @(negedge i_clk);
    chk("ovr_err", bus.o_rx_error, 1);
    pop_chk("ovr_pop", ovr_vec[0]);
    chk("ovr_rts_back", o_rts, 1);
    for (int i = 1; i < 8; i++) pop_chk("ovr_pop", ovr_vec[i]);
    @(negedge i_clk);
    chk("ovr_empty", bus.o_rx_rdy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
